clk_duty_meter: RTL and testbench

Synthesizable meter that measures the period and high time of an incoming digital signal in units of the local clock. It is the receiving end of the team's clock-generation benches: it recovers the frequency and duty cycle that a generator produced. It sits after any pad or clock-mux, sampling `sig_in` asynchronously, and reports one result per input period to a register bank or a bench scoreboard.

---
 rtl/clk_meas_pkg.sv | 17 +
 rtl/clk_duty_meter_seq_divider.sv | 64 ++++++
 rtl/clk_duty_meter.sv | 159 +++++++++++++++
 tb/tb_clk_duty_meter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock duty meter.
//   cdm_state_t : measurement FSM states
//   DUTY_SCALE  : scale factor of the duty result (percent)
//   DUTY_W      : width of the duty result
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } cdm_state_t;

  localparam int DUTY_SCALE = 100;
  localparam int DUTY_W     = 7;

endpackage

// File: rtl/clk_duty_meter_seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock.
//   start    : loads operands and (re)starts; a start during a division
//              abandons it and its result is never published
//   dividend : DIVIDEND_W-bit numerator
//   divisor  : DIVISOR_W-bit denominator (caller guarantees non-zero)
//   done     : one-cycle pulse, DIVIDEND_W cycles after start
//   quotient : result of the last completed division, holds until next done
module seq_divider #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int STEP_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W:0]    rem, rem_sh, diff, rem_nx;
  logic [DIVIDEND_W-1:0] quo, quo_nx;
  logic [DIVISOR_W-1:0]  dvs;
  logic [STEP_W-1:0]     steps;

  // Shift the next dividend bit into the partial remainder and try a
  // subtraction; the MSB of diff is the borrow (remainder < divisor).
  always_comb begin
    rem_sh = {rem[DIVISOR_W-1:0], quo[DIVIDEND_W-1]};
    diff   = rem_sh - {1'b0, dvs};
    rem_nx = diff[DIVISOR_W] ? rem_sh : diff;
    quo_nx = {quo[DIVIDEND_W-2:0], ~diff[DIVISOR_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      steps    <= '0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= '0;
        quo   <= dividend;
        dvs   <= divisor;
        steps <= STEP_W'(DIVIDEND_W);
      end else if (steps != '0) begin
        rem   <= rem_nx;
        quo   <= quo_nx;
        steps <= steps - 1'b1;
        if (steps == STEP_W'(1)) begin
          done     <= 1'b1;
          quotient <= quo_nx;
        end
      end
    end
  end

endmodule

// File: rtl/clk_duty_meter.sv
// clk_duty_meter: measures period and high time of an asynchronous signal
// in clk cycles, one result per input period, back-to-back.
// Optional feature macro: CDM_DUTY_PCT_EN (adds duty_pct/duty_valid and a
// sequential divider).
//   clk, rst   : sampling clock, asynchronous active-high reset
//   en         : measurement enable; low aborts and parks the FSM in IDLE
//   sig_in     : signal under measurement (asynchronous)
//   period_cnt : last period in clk cycles
//   high_cnt   : last high time in clk cycles
//   meas_valid : one-cycle pulse when period_cnt/high_cnt update
//   fsm_state  : current FSM state (debug)
//   overflow   : sticky, a period exceeded 2^CNT_W-1; cleared by a result
//   duty_pct   : floor(high*100/period), clamped to 100 (macro only)
//   duty_valid : one-cycle pulse when duty_pct updates (macro only)
// Handshake: meas_valid and duty_valid are single-cycle strobes with no
// back-pressure; the data they qualify holds until the next strobe.
module clk_duty_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2    // must be >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output cdm_state_t       fsm_state,
  output logic             overflow
`ifdef CDM_DUTY_PCT_EN
  ,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              duty_valid
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise_q, fall_q;
  cdm_state_t             state;
  logic [CNT_W-1:0]       pcnt, hcnt;
  logic                   close;

  assign s         = sync[SYNC_STAGES-1];
  assign fsm_state = state;
  // A rise seen in MEAS_LOW closes the current period and publishes it.
  assign close     = en && (state == MEAS_LOW) && rise_q;

  // Edge flags are registered; this shifts every edge by the same cycle so
  // counts are unaffected, and keeps the FSM off the synchronizer output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      s_d    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
      rise_q <= s & ~s_d;
      fall_q <= ~s & s_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      hcnt       <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
        pcnt  <= '0;
        hcnt  <= '0;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_RISE;
          WAIT_RISE: begin
            // Partial cycle in progress at enable is discarded.
            if (rise_q) begin
              state <= MEAS_HIGH;
              pcnt  <= CNT_W'(1);
              hcnt  <= CNT_W'(1);
            end
          end
          MEAS_HIGH: begin
            // Saturation outranks the fall: both paths increment pcnt.
            if (pcnt == CNT_MAX) begin
              overflow <= 1'b1;
              state    <= WAIT_RISE;
              pcnt     <= '0;
              hcnt     <= '0;
            end else if (fall_q) begin
              state <= MEAS_LOW;
              pcnt  <= pcnt + 1'b1;
            end else begin
              pcnt <= pcnt + 1'b1;
              hcnt <= hcnt + 1'b1;
            end
          end
          MEAS_LOW: begin
            // The closing rise does not increment, so it cannot overflow.
            if (rise_q) begin
              period_cnt <= pcnt;
              high_cnt   <= hcnt;
              meas_valid <= 1'b1;
              overflow   <= 1'b0;
              state      <= MEAS_HIGH;
              pcnt       <= CNT_W'(1);
              hcnt       <= CNT_W'(1);
            end else if (pcnt == CNT_MAX) begin
              overflow <= 1'b1;
              state    <= WAIT_RISE;
              pcnt     <= '0;
              hcnt     <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CDM_DUTY_PCT_EN
  localparam int DIV_W = CNT_W + DUTY_W;

  logic [DIV_W-1:0] div_q;

  // Started from the same condition that latches the result, with the raw
  // counters as operands, so duty_valid lands exactly DIV_W cycles after
  // meas_valid.
  seq_divider #(
    .DIVIDEND_W(DIV_W),
    .DIVISOR_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (close),
    .dividend(DIV_W'(hcnt) * DIV_W'(DUTY_SCALE)),
    .divisor (pcnt),
    .done    (duty_valid),
    .quotient(div_q)
  );

  assign duty_pct = (div_q > DIV_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE)
                                                 : div_q[DUTY_W-1:0];
`endif

endmodule

// File: tb/tb_clk_duty_meter.sv
module tb_clk_duty_meter;
  import clk_meas_pkg::*;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;
  localparam int DIV_LAT     = CNT_W + 7;

  logic             clk = 1'b0;
  logic             rst, en, sig_in;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic             meas_valid, overflow;
  logic [1:0]       fsm_state;
`ifdef CDM_DUTY_PCT_EN
  logic [6:0]       duty_pct;
  logic             duty_valid;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [2*CNT_W-1:0] exp_q[$];
  logic [2*CNT_W-1:0] got_q[$];
  int                 got_cyc[$];
  int                 rise_cyc[$];
  logic [6:0]         duty_q[$];
  int                 duty_cyc[$];

  clk_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .period_cnt(period_cnt),
    .high_cnt  (high_cnt),
    .meas_valid(meas_valid),
    .fsm_state (fsm_state),
    .overflow  (overflow)
`ifdef CDM_DUTY_PCT_EN
    ,
    .duty_pct  (duty_pct),
    .duty_valid(duty_valid)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // result log, sampled on the falling edge
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (meas_valid) begin
        got_q.push_back({period_cnt, high_cnt});
        got_cyc.push_back(cyc);
      end
`ifdef CDM_DUTY_PCT_EN
      if (duty_valid) begin
        duty_q.push_back(duty_pct);
        duty_cyc.push_back(cyc);
      end
`endif
    end
  end

  // driver tasks (called at a falling edge)
  task automatic run_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (hi) @(negedge clk);
      sig_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic park;
    en     = 1'b0;
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    rise_cyc.delete();
    duty_q.delete();
    duty_cyc.delete();
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; sig_in = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (period_cnt !== '0 || high_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d expected 0/0", period_cnt, high_cnt);
    end
    checks++;
    if (meas_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b/%b expected 0/0", meas_valid, overflow);
    end
    checks++;
    if (fsm_state !== 2'(IDLE)) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE);
    end
`ifdef CDM_DUTY_PCT_EN
    checks++;
    if (duty_pct !== 7'd0 || duty_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_duty: got %0d/%b expected 0/0", duty_pct, duty_valid);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_state !== 2'(IDLE)) begin
      errors++;
      $display("FAIL idle_while_disabled: got %0d expected %0d", fsm_state, IDLE);
    end
  endtask

  // 3 high / 5 low: first rise only starts, then 8/3 each period
  task automatic test_basic;
    park();
    en = 1'b1;
    repeat (3) @(negedge clk);
    run_wave(3, 5, 5);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back({8'd8, 8'd3});
    checks++;
    if (got_q.size() !== 4) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_result[%0d]: got %0d/%0d expected 8/3", i, got_q[i][15:8], got_q[i][7:0]);
      end
      checks++;
      if (got_cyc[i] - rise_cyc[i+1] !== LAT) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, got_cyc[i] - rise_cyc[i+1], LAT);
      end
    end
  endtask

  // 2 high / 6 low: 25 % duty
  task automatic test_duty;
    park();
    en = 1'b1;
    repeat (3) @(negedge clk);
    run_wave(2, 6, 3);
    repeat (25) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL duty_count: got %0d expected 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++;
      if (got_q[i] !== {8'd8, 8'd2}) begin
        errors++;
        $display("FAIL duty_result[%0d]: got %0d/%0d expected 8/2", i, got_q[i][15:8], got_q[i][7:0]);
      end
    end
`ifdef CDM_DUTY_PCT_EN
    // second result restarts the divider, so only one duty_valid
    checks++;
    if (duty_q.size() !== 1) begin
      errors++;
      $display("FAIL duty_pct_count: got %0d expected 1", duty_q.size());
    end else begin
      checks++;
      if (duty_q[0] !== 7'd25) begin
        errors++;
        $display("FAIL duty_pct_value: got %0d expected 25", duty_q[0]);
      end
      checks++;
      if (got_q.size() == 2 && duty_cyc[0] - got_cyc[1] !== DIV_LAT) begin
        errors++;
        $display("FAIL duty_pct_latency: got %0d expected %0d", duty_cyc[0] - got_cyc[1], DIV_LAT);
      end
    end
`endif
  endtask

  // en dropped in the high phase: aborted, outputs hold
  task automatic test_en_abort;
    park();
    en = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (period_cnt !== 8'd8 || high_cnt !== 8'd2) begin
      errors++;
      $display("FAIL abort_hold: got %0d/%0d expected 8/2", period_cnt, high_cnt);
    end
    checks++;
    if (fsm_state !== 2'(IDLE)) begin
      errors++;
      $display("FAIL abort_state: got %0d expected %0d", fsm_state, IDLE);
    end
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    run_wave(4, 4, 3);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin
      errors++;
      $display("FAIL abort_count: got %0d expected 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {8'd8, 8'd4} || got_q[1] !== {8'd8, 8'd4}) begin
        errors++;
        $display("FAIL abort_result: got %0d/%0d expected 8/4", got_q[0][15:8], got_q[0][7:0]);
      end
      checks++;
      if (got_cyc[0] - rise_cyc[1] !== LAT) begin
        errors++;
        $display("FAIL abort_first_at_second_rise: got %0d expected %0d", got_cyc[0] - rise_cyc[1], LAT);
      end
    end
  endtask

  // period 8 -> 12 with no gap between results
  task automatic test_back_to_back;
    park();
    en = 1'b1;
    repeat (3) @(negedge clk);
    run_wave(3, 5, 3);
    run_wave(6, 6, 3);
    repeat (25) @(negedge clk);
    exp_q.push_back({8'd8, 8'd3});
    exp_q.push_back({8'd8, 8'd3});
    exp_q.push_back({8'd8, 8'd3});
    exp_q.push_back({8'd12, 8'd6});
    exp_q.push_back({8'd12, 8'd6});
    checks++;
    if (got_q.size() !== 5) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %0d/%0d expected %0d/%0d", i,
                   got_q[i][15:8], got_q[i][7:0], exp_q[i][15:8], exp_q[i][7:0]);
        end
      end
      checks++;
      if (got_cyc[3] - got_cyc[2] !== 12) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d expected 12", got_cyc[3] - got_cyc[2]);
      end
    end
`ifdef CDM_DUTY_PCT_EN
    checks++;
    if (duty_q.size() !== 1 || duty_q[0] !== 7'd50) begin
      errors++;
      $display("FAIL b2b_duty: got %0d results first %0d expected 1 result 50",
               duty_q.size(), (duty_q.size() > 0) ? duty_q[0] : 7'd0);
    end
`endif
  endtask

  // stuck high saturates after 255 counted cycles, then recovers
  task automatic test_overflow;
    park();
    en = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    repeat (258) @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: got %b expected 0", overflow);
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    checks++;
    if (fsm_state !== 2'(WAIT_RISE) || got_q.size() !== 0) begin
      errors++;
      $display("FAIL ovf_no_result: got state %0d results %0d expected %0d/0",
               fsm_state, got_q.size(), WAIT_RISE);
    end
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    run_wave(4, 6, 3);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== {8'd10, 8'd4}) begin
      errors++;
      $display("FAIL ovf_recover: got %0d results expected 2 of 10/4", got_q.size());
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  // asynchronous reset in MEAS_LOW
  task automatic test_reset_mid;
    park();
    en = 1'b1;
    repeat (3) @(negedge clk);
    run_wave(3, 5, 2);
    checks++;
    if (period_cnt !== 8'd8 || fsm_state !== 2'(MEAS_LOW)) begin
      errors++;
      $display("FAIL rstmid_pre: got %0d state %0d expected 8 state %0d", period_cnt, fsm_state, MEAS_LOW);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (period_cnt !== '0 || high_cnt !== '0 || meas_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %0d/%0d/%b/%b expected 0/0/0/0",
               period_cnt, high_cnt, meas_valid, overflow);
    end
    checks++;
    if (fsm_state !== 2'(IDLE)) begin
      errors++;
      $display("FAIL rstmid_state: got %0d expected %0d", fsm_state, IDLE);
    end
`ifdef CDM_DUTY_PCT_EN
    checks++;
    if (duty_pct !== 7'd0) begin
      errors++;
      $display("FAIL rstmid_duty: got %0d expected 0", duty_pct);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty();
    test_en_abort();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
